// File: rtl/gate_ctl_pkg.sv
// Shared types for the gate-controller feeder: field widths, sequencer
// state encoding and the packed command word.
package gate_ctl_pkg;

  localparam int SEL_W = 2;
  localparam int A_W   = 4;
  localparam int B_W   = 2;
  localparam int Y_W   = 4;
  localparam int D_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic cmd_t pack_cmd(logic [SEL_W-1:0] sel, logic [A_W-1:0] a,
                                    logic [B_W-1:0] b);
    cmd_t c;
    c.sel = sel;
    c.a   = a;
    c.b   = b;
    return c;
  endfunction

endpackage

// File: rtl/gate_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; pushes while full and pops
// while empty are ignored so the count can never over- or underflow.
module gate_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked purely by the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gate_cmd_sequencer.sv
// Stream stage in front of the combinational gate controller: buffers
// commands, presents one at a time, and returns the settled Y/D results.
module gate_cmd_sequencer
  import gate_ctl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_sel,
  input  logic [3:0]                    cmd_a,
  input  logic [1:0]                    cmd_b,
  output logic                          ctl_i,
  output logic                          ctl_s1,
  output logic                          ctl_s0,
  output logic [3:0]                    ctl_a,
  output logic [1:0]                    ctl_b,
  input  logic [3:0]                    ctl_y,
  input  logic [3:0]                    ctl_d,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [3:0]                    res_y,
  output logic [3:0]                    res_d,
  output logic [1:0]                    res_sel,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t             state;
  state_t             state_nxt;
  cmd_t               issue_q;
  logic [CNT_W-1:0]   settle_cnt;
  logic               settle_done;
  logic               start_issue;
  logic               capture;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CMD_W-1:0]   fifo_rdata;

  // Held low during reset so nothing presented then can be pushed.
  assign cmd_ready = rst_n && !fifo_full;

  gate_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .pop   (start_issue),
    .wdata (pack_cmd(cmd_sel, cmd_a, cmd_b)),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYC - 1));
  assign capture     = (state == SETTLE) && settle_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new command may start only when the result slot is free or is being
  // drained on this same edge.
  always_comb begin
    state_nxt   = state;
    start_issue = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && (!res_valid || res_ready)) begin
          start_issue = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE:   state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_q <= '0;
    end else if (start_issue) begin
      issue_q <= cmd_t'(fifo_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == ISSUE) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // A capture on the same edge as a consume keeps the slot full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_y     <= '0;
      res_d     <= '0;
      res_sel   <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_y     <= ctl_y;
      res_d     <= ctl_d;
      res_sel   <= issue_q.sel;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign ctl_i  = (state == ISSUE) || (state == SETTLE);
  assign ctl_s1 = issue_q.sel[1];
  assign ctl_s0 = issue_q.sel[0];
  assign ctl_a  = issue_q.a;
  assign ctl_b  = issue_q.b;

endmodule

// File: tb/tb_gate_cmd_sequencer.sv
// Directed bench for gate_cmd_sequencer with a behavioural controller model;
// a second instance built with a longer settle window checks sampling time.
module tb_gate_cmd_sequencer;
  import gate_ctl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid, cmd_ready, ctl_i, ctl_s1, ctl_s0, res_valid, res_ready;
  logic [1:0] cmd_sel, cmd_b, ctl_b, res_sel;
  logic [3:0] cmd_a, ctl_a, ctl_y, ctl_d, res_y, res_d;
  logic [2:0] fifo_count;

  logic       cmd_valid2, cmd_ready2, ctl_i2, ctl_s12, ctl_s02, res_valid2, res_ready2;
  logic [1:0] cmd_sel2, cmd_b2, ctl_b2, res_sel2;
  logic [3:0] cmd_a2, ctl_a2, ctl_y2, ctl_d2, res_y2, res_d2, glitch2;
  logic [2:0] fifo_count2;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] vec[6];
  bit         seen;

  gate_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .ctl_i(ctl_i),
    .ctl_s1(ctl_s1), .ctl_s0(ctl_s0), .ctl_a(ctl_a), .ctl_b(ctl_b),
    .ctl_y(ctl_y), .ctl_d(ctl_d), .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_d(res_d), .res_sel(res_sel), .fifo_count(fifo_count)
  );

  gate_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_sel(cmd_sel2), .cmd_a(cmd_a2), .cmd_b(cmd_b2), .ctl_i(ctl_i2),
    .ctl_s1(ctl_s12), .ctl_s0(ctl_s02), .ctl_a(ctl_a2), .ctl_b(ctl_b2),
    .ctl_y(ctl_y2), .ctl_d(ctl_d2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res_y(res_y2), .res_d(res_d2), .res_sel(res_sel2), .fifo_count(fifo_count2)
  );

  // Controller model; the second copy can have glitches forced onto Y.
  always_comb begin
    ctl_y  = ctl_i ? (ctl_a ^ {2'b00, ctl_b}) : 4'h0;
    ctl_d  = 4'b0001 << ctl_b;
    ctl_y2 = (ctl_i2 ? (ctl_a2 ^ {2'b00, ctl_b2}) : 4'h0) ^ glitch2;
    ctl_d2 = 4'b0001 << ctl_b2;
  end

  function automatic logic [3:0] exp_y(logic [7:0] c);
    return c[5:2] ^ {2'b00, c[1:0]};
  endfunction

  function automatic logic [3:0] exp_d(logic [7:0] c);
    return 4'b0001 << c[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] c);
    cmd_valid = v;
    cmd_sel   = c[7:6];
    cmd_a     = c[5:2];
    cmd_b     = c[1:0];
  endtask

  task automatic pushOne(input logic [7:0] c);
    applyStimulus(1'b1, c);
    tick();
    applyStimulus(1'b0, 8'h00);
  endtask

  task automatic waitResult(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      tick();
      if (res_valid) found = 1'b1;
    end
  endtask

  // Needs res_ready=1; every result seen is consumed on the following edge.
  task automatic drainCheck(input string tag, input int n_exp, input int max_cyc);
    int         got;
    logic [7:0] e;
    got = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (res_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput({tag, "_sel"}, 32'(res_sel), 32'(e[7:6]));
          checkOutput({tag, "_y"},   32'(res_y),   32'(exp_y(e)));
          checkOutput({tag, "_d"},   32'(res_d),   32'(exp_d(e)));
        end
        got++;
      end
      tick();
    end
    checkOutput({tag, "_count"}, 32'(got), 32'(n_exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    res_ready = 1'b0;
    applyStimulus(1'b1, 8'hFF);
    cmd_valid2 = 1'b1; cmd_sel2 = 2'b11; cmd_a2 = 4'hF; cmd_b2 = 2'b11;
    res_ready2 = 1'b0; glitch2 = 4'h0;

    $display("[TB] reset with cmd_valid held high");
    tick();
    tick();
    checkOutput("rst_res_valid", 32'(res_valid), 0);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_ctl_i", 32'(ctl_i), 0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 0);
    checkOutput("rst_res_y", 32'(res_y), 0);
    checkOutput("rst_ctl_a", 32'(ctl_a), 0);
    checkOutput("rst_count2", 32'(fifo_count2), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00);
    cmd_valid2 = 1'b0;
    #1;
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 1);
    tick();
    checkOutput("post_rst_count", 32'(fifo_count), 0);
    checkOutput("post_rst_res_valid", 32'(res_valid), 0);

    $display("[TB] single command latency");
    res_ready = 1'b1;
    pushOne({2'b01, 4'b1110, 2'b10});
    checkOutput("single_count", 32'(fifo_count), 1);
    tick();
    checkOutput("single_issue_ctl_i", 32'(ctl_i), 1);
    checkOutput("single_ctl_s1", 32'(ctl_s1), 0);
    checkOutput("single_ctl_s0", 32'(ctl_s0), 1);
    checkOutput("single_ctl_a", 32'(ctl_a), 32'hE);
    checkOutput("single_ctl_b", 32'(ctl_b), 2);
    checkOutput("single_early1", 32'(res_valid), 0);
    tick();
    checkOutput("single_early2", 32'(res_valid), 0);
    tick();
    checkOutput("single_res_valid", 32'(res_valid), 1);
    checkOutput("single_res_y", 32'(res_y), 32'b1100);
    checkOutput("single_res_d", 32'(res_d), 32'b0100);
    checkOutput("single_res_sel", 32'(res_sel), 1);
    tick();
    checkOutput("single_consumed", 32'(res_valid), 0);
    checkOutput("single_done_ctl_i", 32'(ctl_i), 0);
    checkOutput("single_hold_ctl_a", 32'(ctl_a), 32'hE);

    $display("[TB] back-pressure");
    res_ready = 1'b0;
    vec[0] = {2'b10, 4'b0101, 2'b01};
    vec[1] = {2'b00, 4'b0011, 2'b00};
    vec[2] = {2'b01, 4'b1010, 2'b11};
    vec[3] = {2'b11, 4'b1111, 2'b10};
    vec[4] = {2'b10, 4'b0000, 2'b01};
    vec[5] = {2'b01, 4'b0110, 2'b11};
    pushOne(vec[0]);
    waitResult(10, seen);
    checkOutput("bp_first_seen", 32'(seen), 1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, vec[i]);
      checkOutput("bp_cmd_ready", 32'(cmd_ready), (i < 5) ? 1 : 0);
      tick();
      checkOutput("bp_held_y", 32'(res_y), 32'(exp_y(vec[0])));
      checkOutput("bp_held_valid", 32'(res_valid), 1);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("bp_full_count", 32'(fifo_count), 4);
    checkOutput("bp_full_ready", 32'(cmd_ready), 0);
    checkOutput("bp_no_issue", 32'(ctl_i), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(vec[i]);
    res_ready = 1'b1;
    drainCheck("bp_drain", 5, 40);
    checkOutput("bp_empty", 32'(fifo_count), 0);

    $display("[TB] simultaneous push and pop");
    res_ready = 1'b0;
    vec[0] = {2'b11, 4'b1000, 2'b10};
    vec[1] = {2'b00, 4'b0111, 2'b01};
    vec[2] = {2'b10, 4'b1100, 2'b11};
    vec[3] = {2'b01, 4'b0001, 2'b00};
    pushOne(vec[0]);
    waitResult(10, seen);
    checkOutput("pp_first_seen", 32'(seen), 1);
    pushOne(vec[1]);
    pushOne(vec[2]);
    checkOutput("pp_count_before", 32'(fifo_count), 2);
    res_ready = 1'b1;
    pushOne(vec[3]);
    checkOutput("pp_count_after", 32'(fifo_count), 2);
    checkOutput("pp_issue_ctl_i", 32'(ctl_i), 1);
    checkOutput("pp_issue_ctl_a", 32'(ctl_a), 32'(vec[1][5:2]));
    for (int i = 1; i < 4; i++) exp_q.push_back(vec[i]);
    drainCheck("pp_drain", 3, 30);

    $display("[TB] nine sequential commands across pointer wrap");
    for (int i = 0; i < 9; i++) begin
      logic [7:0] c;
      c = {2'(i), 4'(i * 3 + 1), 2'(i + 2)};
      pushOne(c);
      waitResult(10, seen);
      checkOutput("wrap_seen", 32'(seen), 1);
      checkOutput("wrap_y", 32'(res_y), 32'(exp_y(c)));
      checkOutput("wrap_d", 32'(res_d), 32'(exp_d(c)));
      checkOutput("wrap_sel", 32'(res_sel), 32'(c[7:6]));
    end
    tick();

    $display("[TB] reset during settle");
    res_ready = 1'b0;
    pushOne(8'b01_1001_10);
    waitResult(10, seen);
    checkOutput("rs_first_seen", 32'(seen), 1);
    pushOne(8'b10_0110_01);
    pushOne(8'b11_0011_11);
    pushOne(8'b00_1111_00);
    res_ready = 1'b1;
    pushOne(8'b01_0101_10);
    tick();
    checkOutput("rs_in_settle_ctl_i", 32'(ctl_i), 1);
    checkOutput("rs_queued", 32'(fifo_count), 3);
    rst_n = 1'b0;
    tick();
    checkOutput("rs_res_valid", 32'(res_valid), 0);
    checkOutput("rs_count", 32'(fifo_count), 0);
    checkOutput("rs_ctl_i", 32'(ctl_i), 0);
    checkOutput("rs_ctl_a", 32'(ctl_a), 0);
    checkOutput("rs_ctl_b", 32'(ctl_b), 0);
    checkOutput("rs_ctl_s1", 32'(ctl_s1), 0);
    checkOutput("rs_res_y", 32'(res_y), 0);
    checkOutput("rs_res_d", 32'(res_d), 0);
    checkOutput("rs_res_sel", 32'(res_sel), 0);
    checkOutput("rs_cmd_ready", 32'(cmd_ready), 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("rs_no_stale_valid", 32'(res_valid), 0);
    checkOutput("rs_no_stale_count", 32'(fifo_count), 0);
    pushOne(8'b10_1101_11);
    waitResult(10, seen);
    checkOutput("rs_after_seen", 32'(seen), 1);
    checkOutput("rs_after_y", 32'(res_y), 32'b1110);
    checkOutput("rs_after_d", 32'(res_d), 32'b1000);
    tick();

    $display("[TB] three-cycle settle window with glitches");
    res_ready2 = 1'b1;
    cmd_valid2 = 1'b1; cmd_sel2 = 2'b10; cmd_a2 = 4'b1011; cmd_b2 = 2'b01;
    tick();
    cmd_valid2 = 1'b0;
    tick();
    checkOutput("s3_issue_ctl_i", 32'(ctl_i2), 1);
    checkOutput("s3_issue_ctl_a", 32'(ctl_a2), 32'b1011);
    tick();
    glitch2 = 4'hF;
    checkOutput("s3_settle1_ctl_i", 32'(ctl_i2), 1);
    checkOutput("s3_settle1_ctl_a", 32'(ctl_a2), 32'b1011);
    checkOutput("s3_settle1_ctl_b", 32'(ctl_b2), 1);
    checkOutput("s3_settle1_valid", 32'(res_valid2), 0);
    tick();
    checkOutput("s3_settle2_ctl_i", 32'(ctl_i2), 1);
    checkOutput("s3_settle2_ctl_a", 32'(ctl_a2), 32'b1011);
    checkOutput("s3_settle2_valid", 32'(res_valid2), 0);
    tick();
    glitch2 = 4'h0;
    checkOutput("s3_settle3_ctl_i", 32'(ctl_i2), 1);
    checkOutput("s3_settle3_ctl_s1", 32'(ctl_s12), 1);
    checkOutput("s3_settle3_valid", 32'(res_valid2), 0);
    tick();
    checkOutput("s3_res_valid", 32'(res_valid2), 1);
    checkOutput("s3_res_y", 32'(res_y2), 32'b1010);
    checkOutput("s3_res_d", 32'(res_d2), 32'b0010);
    checkOutput("s3_res_sel", 32'(res_sel2), 2);
    checkOutput("s3_done_ctl_i", 32'(ctl_i2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
